// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// forwarding-mux select codes, the shadow-stage record and register $0.
package hazard_forward_unit_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       regwrite;
      logic       memread;
   } stage_t;

   localparam stage_t STAGE_ZERO = '0;

   // MEM is the younger producer, so its value wins over WB.
   function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
      if (mem_hit)     return FWD_EXMEM;
      else if (wb_hit) return FWD_MEMWB;
      else             return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Register-dependency comparator: a source matches a producing stage only when
// that stage writes the register file and its destination is not $0.
module hazard_match
   import hazard_forward_unit_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] dst,
   input  logic       regwrite,
   output logic       hit
);

   assign hit = regwrite && (dst != REG_ZERO) && (dst == src);

endmodule

// File: rtl/hazard_forward_unit.sv
// Five-stage MIPS hazard controller: forwarding selects, load-use stall, branch flush.
// Define HAZARD_FORWARD_EN for forwarding; without it dependencies stall until WB.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IdRs,
   input  logic [4:0] IdRt,
   input  logic [4:0] IdDst,
   input  logic       IdRegWrite,
   input  logic       IdMemRead,
   input  logic       IdUsesRt,
   input  logic       BranchTaken,
   output logic [1:0] ForwardA,
   output logic [1:0] ForwardB,
   output logic       Stall,
   output logic       PCWrite,
   output logic       IFIDWrite,
   output logic       IFIDFlush,
   output logic       IDEXBubble
);

   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;
   stage_t id_entry;

   logic ex_gate;
   logic id_rs_ex_hit;
   logic id_rt_ex_hit;
   logic stall_raw;

   assign id_entry = '{rs: IdRs, rt: IdRt, dst: IdDst,
                       regwrite: IdRegWrite, memread: IdMemRead};

   // Shadow destination pipeline, advancing in lock-step with the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= STAGE_ZERO;
         mem_q <= STAGE_ZERO;
         wb_q  <= STAGE_ZERO;
      end else begin
         ex_q  <= IDEXBubble ? STAGE_ZERO : id_entry;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   hazard_match u_id_rs_ex (
      .src      (IdRs),
      .dst      (ex_q.dst),
      .regwrite (ex_gate),
      .hit      (id_rs_ex_hit)
   );

   hazard_match u_id_rt_ex (
      .src      (IdRt),
      .dst      (ex_q.dst),
      .regwrite (ex_gate),
      .hit      (id_rt_ex_hit)
   );

`ifdef HAZARD_FORWARD_EN
   logic ex_rs_mem_hit;
   logic ex_rs_wb_hit;
   logic ex_rt_mem_hit;
   logic ex_rt_wb_hit;
   logic unused_fwd;

   // Only a load in EX cannot be forwarded in time for the ID instruction.
   assign ex_gate = ex_q.memread;

   hazard_match u_ex_rs_mem (
      .src      (ex_q.rs),
      .dst      (mem_q.dst),
      .regwrite (mem_q.regwrite),
      .hit      (ex_rs_mem_hit)
   );

   hazard_match u_ex_rs_wb (
      .src      (ex_q.rs),
      .dst      (wb_q.dst),
      .regwrite (wb_q.regwrite),
      .hit      (ex_rs_wb_hit)
   );

   hazard_match u_ex_rt_mem (
      .src      (ex_q.rt),
      .dst      (mem_q.dst),
      .regwrite (mem_q.regwrite),
      .hit      (ex_rt_mem_hit)
   );

   hazard_match u_ex_rt_wb (
      .src      (ex_q.rt),
      .dst      (wb_q.dst),
      .regwrite (wb_q.regwrite),
      .hit      (ex_rt_wb_hit)
   );

   assign ForwardA  = fwd_select(ex_rs_mem_hit, ex_rs_wb_hit);
   assign ForwardB  = fwd_select(ex_rt_mem_hit, ex_rt_wb_hit);
   assign stall_raw = id_rs_ex_hit || (id_rt_ex_hit && IdUsesRt);

   assign unused_fwd = ^{ex_q.regwrite, mem_q.rs, mem_q.rt, mem_q.memread,
                         wb_q.rs, wb_q.rt, wb_q.memread};
`else
   logic id_rs_mem_hit;
   logic id_rt_mem_hit;
   logic unused_nofwd;

   // Any pending writer in EX or MEM blocks; WB is covered by the early RF write.
   assign ex_gate = ex_q.regwrite;

   hazard_match u_id_rs_mem (
      .src      (IdRs),
      .dst      (mem_q.dst),
      .regwrite (mem_q.regwrite),
      .hit      (id_rs_mem_hit)
   );

   hazard_match u_id_rt_mem (
      .src      (IdRt),
      .dst      (mem_q.dst),
      .regwrite (mem_q.regwrite),
      .hit      (id_rt_mem_hit)
   );

   assign ForwardA  = FWD_REG;
   assign ForwardB  = FWD_REG;
   assign stall_raw = id_rs_ex_hit || id_rs_mem_hit ||
                      (IdUsesRt && (id_rt_ex_hit || id_rt_mem_hit));

   assign unused_nofwd = ^{ex_q.rs, ex_q.rt, ex_q.memread,
                           mem_q.rs, mem_q.rt, mem_q.memread, wb_q};
`endif

   // A taken branch kills the ID instruction, so a stall on it is moot.
   assign IFIDFlush  = BranchTaken && rst_n;
   assign Stall      = stall_raw && !IFIDFlush;
   assign PCWrite    = !Stall;
   assign IFIDWrite  = !Stall;
   assign IDEXBubble = Stall || IFIDFlush;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: per-cycle expected output vectors
// are queued by the driver and checked by an independent monitor.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic [4:0] IdDst;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic       IdUsesRt;
  logic       BranchTaken;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       Stall;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IFIDFlush;
  logic       IDEXBubble;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];

  hazard_forward_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IdRs        (IdRs),
    .IdRt        (IdRt),
    .IdDst       (IdDst),
    .IdRegWrite  (IdRegWrite),
    .IdMemRead   (IdMemRead),
    .IdUsesRt    (IdUsesRt),
    .BranchTaken (BranchTaken),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .Stall       (Stall),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .IFIDFlush   (IFIDFlush),
    .IDEXBubble  (IDEXBubble)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected vector: {ForwardA, ForwardB, Stall, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
  function automatic logic [8:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic fl);
    return {fa, fb, st, ~st, ~st, fl, st | fl};
  endfunction

  // driver: present one ID-stage instruction for a cycle and queue the expected outputs
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input logic rw, input logic mr,
                      input logic ur, input logic br, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st, input logic fl,
                      input string nm);
    @(posedge clk);
    #1;
    rst_n       = rst;
    IdRs        = rs;
    IdRt        = rt;
    IdDst       = dst;
    IdRegWrite  = rw;
    IdMemRead   = mr;
    IdUsesRt    = ur;
    BranchTaken = br;
    exp_q.push_back(ev(fa, fb, st, fl));
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] exp_v;
      logic [8:0] act_v;
      string      nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {ForwardA, ForwardB, Stall, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got fa/fb/st/pc/ifid/fl/bub=%b expected %b", nm, act_v, exp_v);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    IdRs = '0; IdRt = '0; IdDst = '0;
    IdRegWrite = 1'b0; IdMemRead = 1'b0; IdUsesRt = 1'b0; BranchTaken = 1'b0;
    repeat (2) @(posedge clk);
    //    rst rs  rt  dst rw mr ur br  fa     fb     st fl
    step(0,  1,  2,  3,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "reset_state");
`ifdef HAZARD_FORWARD_EN
    step(1,  1,  2,  3,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "first_add");
    step(1,  3,  4,  5,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "sub_in_id");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b01, 2'b00, 0, 0, "back2back_fa");
    step(1,  7,  5,  6,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "or_in_id");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b10, 0, 0, "dist2_fb");
    step(1,  1,  1,  3,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "dbl_first");
    step(1,  2,  2,  3,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "dbl_second");
    step(1,  7,  3, 10,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "dbl_reader");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b01, 0, 0, "double_hit");
    step(1,  1,  2,  2,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_in_id");
    step(1,  2,  5,  4,  1, 0, 1, 0, 2'b00, 2'b00, 1, 0, "loaduse_stall");
    step(1,  2,  5,  4,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "loaduse_once");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b10, 2'b00, 0, 0, "loaduse_fa");
    step(1,  1,  2,  0,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "wr_zero_id");
    step(1,  0,  0,  7,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "rd_zero_id");
    step(1,  1,  8,  8,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "zero_dst");
    step(1,  1,  8,  9,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "usesrt0_nostall");
    step(1,  1, 11, 11,  1, 1, 0, 0, 2'b00, 2'b01, 0, 0, "mem_rt_fwd");
    step(1,  3, 11, 12,  1, 0, 1, 1, 2'b00, 2'b00, 0, 1, "stall_vs_flush");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "after_flush");
    step(1,  1,  2,  2,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_again");
    step(0,  2,  2,  4,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "reset_mid");
    step(1,  2,  2,  4,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "post_reset");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "no_residual");
`else
    step(1,  1,  2,  3,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "first_add");
    step(1,  3,  4,  5,  1, 0, 1, 0, 2'b00, 2'b00, 1, 0, "nf_stall1");
    step(1,  3,  4,  5,  1, 0, 1, 0, 2'b00, 2'b00, 1, 0, "nf_stall2");
    step(1,  3,  4,  5,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "nf_release");
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "nf_fa_tied");
    step(1,  7,  5,  6,  1, 0, 1, 0, 2'b00, 2'b00, 1, 0, "nf_mem_rt");
    step(1,  5,  0,  8,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "nf_wb_free");
    step(1,  8,  0,  9,  1, 0, 1, 1, 2'b00, 2'b00, 0, 1, "nf_flush_wins");
    step(1,  1,  2,  2,  1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "nf_lw_id");
    step(1,  1,  2, 11,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "nf_usesrt0");
    step(1,  1,  1,  0,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "nf_wr_zero");
    step(1,  0,  0, 12,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "nf_zero");
    step(0, 12, 12, 13,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "reset_mid");
    step(1, 12, 12, 13,  1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "post_reset");
`endif
    step(1,  0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "idle_tail");
    // bounded drain of the scoreboard
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the five-stage MIPS datapath. It drives the 2-bit selects of the ALU-operand forwarding muxes (00 register file, 01 EX/MEM, 10 MEM/WB, 11 reserved). It also generates the load-use stall and branch-flush controls for the PC, IF/ID and ID/EX registers. It keeps its own shadow copy of the destination-register pipeline (EX, MEM, WB) and advances it in lock-step with the datapath registers.

## Interface
- No parameters; register index width fixed at 5, selects fixed at 2 bits.
- clk  in  1  rising-edge clock shared with the datapath.
- rst_n  in  1  asynchronous, active-low reset.
- IdRs  in  5  rs field of the instruction in ID.
- IdRt  in  5  rt field of the instruction in ID.
- IdDst  in  5  destination register in ID, after the RegDst mux.
- IdRegWrite  in  1  ID instruction writes the register file.
- IdMemRead  in  1  ID instruction is a load.
- IdUsesRt  in  1  ID instruction reads rt as a source (R-type, SW, BEQ).
- BranchTaken  in  1  branch or jump resolved taken in EX this cycle.
- ForwardA  out  2  select for the ALU operand A mux (EX instruction).
- ForwardB  out  2  select for the ALU operand B mux (EX instruction).
- Stall  out  1  hold PC and IF/ID this cycle.
- PCWrite  out  1  equals ~Stall.
- IFIDWrite  out  1  equals ~Stall.
- IFIDFlush  out  1  clear IF/ID at the next edge.
- IDEXBubble  out  1  load a NOP into ID/EX at the next edge (Stall | IFIDFlush).

## Operation
- Shadow stages: EX, MEM, WB each hold {rs, rt, dst, regwrite, memread}.
- Every rising edge, unconditionally:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= IDEXBubble ? zero entry : ID fields.
- Zero entry: all fields 0, regwrite = 0.
- A destination of $0 never matches. A stage with regwrite = 0 never matches.
- ForwardA for EX.rs:
  - 01 if MEM.regwrite and MEM.dst == EX.rs != 0.
  - Otherwise 10 if WB matches EX.rs.
  - Otherwise 00.
  - MEM has priority over WB (newest value wins).
- ForwardB: same rule applied to EX.rt.
- 11 is never driven.
- Load-use stall: Stall = 1 when EX.memread, EX.dst != 0, and either:
  - EX.dst == IdRs, or
  - EX.dst == IdRt with IdUsesRt.
- Branch: BranchTaken → IFIDFlush = 1 and IDEXBubble = 1, killing the IF and ID instructions.
- Stall and BranchTaken in the same cycle: flush wins. Stall = 0, PCWrite = 1, and the PC loads the target.
- The register file writes in the first half-cycle. A WB write and an ID read of the same register in the same cycle need no handling here.

## Timing
- ForwardA/B, Stall, IFIDFlush and IDEXBubble are combinational from the shadow registers and the ID/EX inputs. They are valid in the same cycle and must settle before the edge.
- Shadow registers: one-cycle advance per edge, no enable.
- Load-use penalty: exactly 1 bubble. The dependent instruction then receives ForwardA/B = 10 in EX.
- Taken-branch penalty: 2 killed instructions.
- Reset, asynchronous, clearing mid-operation as well:
  - All shadow stages become zero entries.
  - ForwardA/B = 00, Stall = 0, PCWrite = 1, IFIDWrite = 1, IFIDFlush = 0, IDEXBubble = 0.
- First edge after release: normal operation, no residual hazards.

## Configuration
- HAZARD_FORWARD_EN defined (default build):
  - Behaviour exactly as above.
- HAZARD_FORWARD_EN undefined:
  - ForwardA/B are tied to 00.
  - Stall = 1 while any source of the ID instruction (rs, and rt if IdUsesRt) matches a nonzero regwrite destination in EX or MEM.
  - Penalty is up to 2 bubbles; WB is covered by the half-cycle register-file write.
  - Flush priority is unchanged.

## Structure
- Shared package holds:
  - FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - The shadow-stage struct {rs, rt, dst, regwrite, memread}.
  - REG_ZERO = 5'd0.
- One sub-module: hazard_match, a combinational comparator (src, dst, regwrite → hit, with the $0 guard). It is instantiated once per source/stage pair.

## Test plan
- Back-to-back ALU ops: add $3,$1,$2 then sub $5,$3,$4 → ForwardA = 01 while sub is in EX. No stall.
- Distance two: add $3,... ; nop ; or $6,$7,$3 → ForwardB = 10 for the or. A MEM/WB double hit on $3 selects 01.
- Load-use: lw $2,0($1) then add $4,$2,$5 → Stall = 1 for exactly one cycle with IDEXBubble = 1. Then the add gets ForwardA = 10.
- Writes to $0 plus IdUsesRt = 0: add $0,... followed by reader of $0 → selects 00, Stall = 0. lw $8 then addi $9,$1,5 with IdRt = 8 → no stall.
- Stall and BranchTaken in the same cycle → IFIDFlush = 1, Stall = 0, PCWrite = 1. rst_n pulsed low mid-stream → all outputs at reset values immediately.
- Build without HAZARD_FORWARD_EN: add $3 then sub using $3 → Stall high for 2 cycles, ForwardA = 00 throughout.
